// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the fetch stage.
//   Holds the opcode constants used by the predecoder, the NOP word that fills an
//   empty instruction register, and the fetch FSM state encoding.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   req/addr   : fetch request and address (master -> memory)
//   ready      : memory accepts the request this cycle (req && ready = accept)
//   rvalid     : response valid, one per accepted request
//   rdata      : 32-bit instruction word
interface fetch_stage_if #(
   parameter int XLEN = 64
);

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic            rvalid;
   logic [31:0]     rdata;

   modport master (output req, addr, input ready, rvalid, rdata);
   modport slave  (input req, addr, output ready, rvalid, rdata);

endinterface

// File: rtl/instr_predecode.sv
// instr_predecode: combinational opcode classifier.
//   opcode    in  7  instruction bits [6:0]
//   is_load   out 1  load opcode
//   is_store  out 1  store opcode
//   is_branch out 1  conditional branch opcode
//   is_jump   out 1  JALR opcode (I-type immediate)
// At most one output is set; any other opcode gives all zero.
module instr_predecode
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jump
);

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jump   = (opcode == OPC_JALR);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: multicycle instruction fetch.
//   clk, reset       clock, synchronous active-high reset
//   imem             instruction-memory bus (master side)
//   instr_out/pc_out instruction register and its PC
//   instr_valid      instr_out/pc_out/flags valid for decode
//   decode_ready     decode consumes the instruction when instr_valid is high
//   isLoad..isJump   predecoded opcode class of instr_out
//   redirect_valid   replace the PC with redirect_pc (low two bits forced 0)
// One request is outstanding at a time: S_REQ issues it, S_WAIT collects the
// response, S_HOLD presents it to decode. All outputs are registered.
module fetch_stage #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   fetch_stage_if.master     imem,
   output logic [31:0]       instr_out,
   output logic [XLEN-1:0]   pc_out,
   output logic              instr_valid,
   input  logic              decode_ready,
   output logic              isLoad,
   output logic              isStore,
   output logic              isBranch,
   output logic              isJump,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc
);

   import riscv_pkg::*;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            drop;   // response of the outstanding request must be discarded

   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] pc_next;
   logic            accept;
   logic            pd_load, pd_store, pd_branch, pd_jump;

   assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
   assign pc_next  = pc + XLEN'(4);   // wraps modulo 2^XLEN
   assign accept   = imem.req && imem.ready;

   instr_predecode u_predecode (
      .opcode    (imem.rdata[6:0]),
      .is_load   (pd_load),
      .is_store  (pd_store),
      .is_branch (pd_branch),
      .is_jump   (pd_jump)
   );

   // Every transition back into S_REQ also raises imem.req with the new address,
   // so a handoff or discarded response costs only one cycle before the next fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         drop        <= 1'b0;
         imem.req    <= 1'b0;
         imem.addr   <= RESET_PC;
         instr_out   <= NOP_INSTR;
         pc_out      <= RESET_PC;
         instr_valid <= 1'b0;
         isLoad      <= 1'b0;
         isStore     <= 1'b0;
         isBranch    <= 1'b0;
         isJump      <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  pc <= redir_pc;
                  if (accept) begin
                     // The accepted request targets the old PC; throw its data away.
                     state    <= S_WAIT;
                     drop     <= 1'b1;
                     imem.req <= 1'b0;
                  end else begin
                     imem.req  <= 1'b1;
                     imem.addr <= redir_pc;
                  end
               end else if (accept) begin
                  state    <= S_WAIT;
                  imem.req <= 1'b0;
               end else begin
                  imem.req  <= 1'b1;
                  imem.addr <= pc;
               end
            end

            S_WAIT: begin
               if (redirect_valid) begin
                  pc <= redir_pc;
                  if (imem.rvalid) begin
                     state     <= S_REQ;
                     drop      <= 1'b0;
                     imem.req  <= 1'b1;
                     imem.addr <= redir_pc;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem.rvalid) begin
                  if (drop) begin
                     state     <= S_REQ;
                     drop      <= 1'b0;
                     imem.req  <= 1'b1;
                     imem.addr <= pc;
                  end else begin
                     state       <= S_HOLD;
                     instr_out   <= imem.rdata;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     isLoad      <= pd_load;
                     isStore     <= pd_store;
                     isBranch    <= pd_branch;
                     isJump      <= pd_jump;
                  end
               end
            end

            S_HOLD: begin
               // Redirect wins over a same-cycle handoff: no +4.
               if (redirect_valid || decode_ready) begin
                  state       <= S_REQ;
                  instr_out   <= NOP_INSTR;
                  instr_valid <= 1'b0;
                  isLoad      <= 1'b0;
                  isStore     <= 1'b0;
                  isBranch    <= 1'b0;
                  isJump      <= 1'b0;
                  imem.req    <= 1'b1;
                  if (redirect_valid) begin
                     pc        <= redir_pc;
                     imem.addr <= redir_pc;
                  end else begin
                     pc        <= pc_next;
                     imem.addr <= pc_next;
                  end
               end
            end

            default: begin
               state    <= S_REQ;
               imem.req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, self-checking bench for fetch_stage.
//   Two instances share all inputs: dut_a uses RESET_PC=0, dut_b starts at the
//   top of the address space to exercise PC wrap-around.
module tb_fetch_stage;

   import riscv_pkg::*;

   localparam int          XLEN       = 64;
   localparam logic [63:0] B_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        decode_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;

   fetch_stage_if #(.XLEN(XLEN)) ia ();
   fetch_stage_if #(.XLEN(XLEN)) ib ();

   assign ia.ready  = ready;
   assign ia.rvalid = rvalid;
   assign ia.rdata  = rdata;
   assign ib.ready  = ready;
   assign ib.rvalid = rvalid;
   assign ib.rdata  = rdata;

   logic [31:0] instr_a, instr_b;
   logic [63:0] pc_a, pc_b;
   logic        valid_a, valid_b;
   logic        ld_a, st_a, br_a, jp_a;
   logic        ld_b, st_b, br_b, jp_b;

   fetch_stage #(.XLEN(XLEN), .RESET_PC(64'h0)) dut_a (
      .clk(clk), .reset(reset), .imem(ia),
      .instr_out(instr_a), .pc_out(pc_a), .instr_valid(valid_a),
      .decode_ready(decode_ready),
      .isLoad(ld_a), .isStore(st_a), .isBranch(br_a), .isJump(jp_a),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   fetch_stage #(.XLEN(XLEN), .RESET_PC(B_RESET_PC)) dut_b (
      .clk(clk), .reset(reset), .imem(ib),
      .instr_out(instr_b), .pc_out(pc_b), .instr_valid(valid_b),
      .decode_ready(decode_ready),
      .isLoad(ld_b), .isStore(st_b), .isBranch(br_b), .isJump(jp_b),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] word;
      logic [3:0]  flags;   // {load, store, branch, jump}
   } vec_t;

   initial begin
      vec_t        vt [7];
      logic [63:0] epc;

      vt[0] = '{32'h00813083, 4'b1000};   // ld
      vt[1] = '{32'h00a12023, 4'b0100};   // sw
      vt[2] = '{32'hfe000ee3, 4'b0010};   // beq
      vt[3] = '{32'h000080e7, 4'b0001};   // jalr
      vt[4] = '{32'h00000033, 4'b0000};   // add
      vt[5] = '{32'h0000006f, 4'b0000};   // jal is not flagged
      vt[6] = '{32'h00000013, 4'b0000};   // addi

      // ---- reset state
      step();
      step();
      chk("rst_req",   {63'h0, ia.req}, 64'h0);
      chk("rst_addr",  ia.addr, 64'h0);
      chk("rst_instr", {32'h0, instr_a}, {32'h0, NOP_INSTR});
      chk("rst_pc",    pc_a, 64'h0);
      chk("rst_valid", {63'h0, valid_a}, 64'h0);
      chk("rst_flags", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h0);
      chk("rst_addr_b", ib.addr, B_RESET_PC);
      reset = 1'b0;

      // ---- 1: first fetch, minimum latency, handoff
      step();
      chk("t1_req_rise", {63'h0, ia.req}, 64'h1);
      chk("t1_addr", ia.addr, 64'h0);
      ready = 1'b1;
      step();                                   // accept
      ready = 1'b0;
      chk("t1_req_drop", {63'h0, ia.req}, 64'h0);
      chk("t1_valid_early", {63'h0, valid_a}, 64'h0);
      rvalid = 1'b1; rdata = 32'h00813083;
      step();                                   // latch
      rvalid = 1'b0;
      chk("t1_valid", {63'h0, valid_a}, 64'h1);
      chk("t1_instr", {32'h0, instr_a}, 64'h00813083);
      chk("t1_isload", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h8);
      chk("t1_pc_out", pc_a, 64'h0);
      chk("t6_pc_out_b", pc_b, B_RESET_PC);
      decode_ready = 1'b1;
      step();                                   // handoff
      decode_ready = 1'b0;
      chk("t1_valid_clr", {63'h0, valid_a}, 64'h0);
      chk("t1_next_req", {63'h0, ia.req}, 64'h1);
      chk("t1_next_addr", ia.addr, 64'h4);
      chk("t6_wrap_addr_b", ib.addr, 64'h0);

      // ---- 2: memory stalls, late response
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_req_hold", {63'h0, ia.req}, 64'h1);
         chk("t2_addr_hold", ia.addr, 64'h4);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_no_refetch", {62'h0, ia.req, valid_a}, 64'h0);
      end
      rvalid = 1'b1; rdata = 32'h00002003;    // lw
      step();
      rvalid = 1'b0;
      chk("t2_valid", {63'h0, valid_a}, 64'h1);
      chk("t2_instr", {32'h0, instr_a}, 64'h00002003);
      chk("t2_pc_out", pc_a, 64'h4);

      // ---- 3: decode stalls in S_HOLD
      rdata = 32'h00000063;                     // bus noise must not reach instr_out
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_valid", {63'h0, valid_a}, 64'h1);
         chk("t3_hold_instr", {32'h0, instr_a}, 64'h00002003);
         chk("t3_hold_flags", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h8);
         chk("t3_no_req", {63'h0, ia.req}, 64'h0);
      end
      decode_ready = 1'b1;
      step();
      decode_ready = 1'b0;
      chk("t3_next_addr", ia.addr, 64'h8);

      // ---- 4: redirect while waiting, stale response discarded
      ready = 1'b1;
      step();
      ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h103;   // low bits are dropped
      step();
      redirect_valid = 1'b0;
      chk("t4_wait_req", {63'h0, ia.req}, 64'h0);
      rvalid = 1'b1; rdata = 32'h00000063;
      step();
      rvalid = 1'b0;
      chk("t4_stale_valid", {63'h0, valid_a}, 64'h0);
      chk("t4_stale_flags", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h0);
      chk("t4_req", {63'h0, ia.req}, 64'h1);
      chk("t4_addr", ia.addr, 64'h100);
      ready = 1'b1;
      step();
      ready = 1'b0;
      rvalid = 1'b1; rdata = 32'h000080e7;
      step();
      rvalid = 1'b0;
      chk("t4_new_instr", {32'h0, instr_a}, 64'h000080e7);
      chk("t4_new_pc", pc_a, 64'h100);
      chk("t4_isjump", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h1);

      // ---- 5: redirect and decode_ready together in S_HOLD
      decode_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
      step();
      decode_ready = 1'b0; redirect_valid = 1'b0;
      chk("t5_valid", {63'h0, valid_a}, 64'h0);
      chk("t5_addr", ia.addr, 64'h200);

      // ---- redirect on the accept cycle
      ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
      step();
      ready = 1'b0; redirect_valid = 1'b0;
      chk("rq_acc_req", {63'h0, ia.req}, 64'h0);
      rvalid = 1'b1; rdata = 32'h00000023;
      step();
      rvalid = 1'b0;
      chk("rq_acc_valid", {63'h0, valid_a}, 64'h0);
      chk("rq_acc_addr", ia.addr, 64'h300);

      // ---- redirect coinciding with the response
      ready = 1'b1;
      step();
      ready = 1'b0;
      rvalid = 1'b1; rdata = 32'h00000063; redirect_valid = 1'b1; redirect_pc = 64'h400;
      step();
      rvalid = 1'b0; redirect_valid = 1'b0;
      chk("rv_redir_valid", {63'h0, valid_a}, 64'h0);
      chk("rv_redir_req", {63'h0, ia.req}, 64'h1);
      chk("rv_redir_addr", ia.addr, 64'h400);

      // ---- stray response with nothing outstanding
      rvalid = 1'b1; rdata = 32'h00000003;
      step();
      rvalid = 1'b0;
      chk("stray_valid", {63'h0, valid_a}, 64'h0);
      chk("stray_addr", ia.addr, 64'h400);

      // ---- redirect in S_REQ without accept
      redirect_valid = 1'b1; redirect_pc = 64'h500;
      step();
      redirect_valid = 1'b0;
      chk("rq_redir_req", {63'h0, ia.req}, 64'h1);
      chk("rq_redir_addr", ia.addr, 64'h500);

      // ---- opcode table
      epc = 64'h500;
      for (int i = 0; i < 7; i++) begin
         ready = 1'b1;
         step();
         ready = 1'b0;
         rvalid = 1'b1; rdata = vt[i].word;
         step();
         rvalid = 1'b0;
         chk("tbl_valid", {63'h0, valid_a}, 64'h1);
         chk("tbl_instr", {32'h0, instr_a}, {32'h0, vt[i].word});
         chk("tbl_pc", pc_a, epc);
         chk("tbl_flags", {60'h0, ld_a, st_a, br_a, jp_a}, {60'h0, vt[i].flags});
         decode_ready = 1'b1;
         step();
         decode_ready = 1'b0;
         epc = epc + 64'h4;
         chk("tbl_flags_clr", {59'h0, valid_a, ld_a, st_a, br_a, jp_a}, 64'h0);
         chk("tbl_next_addr", ia.addr, epc);
      end

      // ---- reset mid-transaction, late response ignored
      ready = 1'b1;
      step();
      ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_req", {63'h0, ia.req}, 64'h0);
      rvalid = 1'b1; rdata = 32'h00000003;
      step();
      rvalid = 1'b0;
      chk("mid_rst_valid", {63'h0, valid_a}, 64'h0);
      chk("mid_rst_flags", {60'h0, ld_a, st_a, br_a, jp_a}, 64'h0);
      chk("mid_rst_addr", ia.addr, 64'h0);
      chk("mid_rst_addr_b", ib.addr, B_RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
